pulse_interval_meter: RTL and testbench

- Receive-side counterpart to the function generator's start_pulse/stop_pulse outputs.
- Measures the number of m_clk cycles from a start_pulse rising edge to the next stop_pulse rising edge.
- Reports the result through a valid/ready result port, with a timeout for a missing stop.
- Sits beside the generator in the top level; feeds result logic and display logic.

---
 rtl/pulse_interval_meter_pkg.sv | 13 +
 rtl/pulse_interval_meter_if.sv | 34 +++
 rtl/pulse_interval_meter_edge_detect.sv | 40 ++++
 rtl/pulse_interval_meter.sv | 98 +++++++++
 tb/tb_pulse_interval_meter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pulse_interval_meter_pkg.sv
// Shared types and defaults for the pulse interval meter.
package fgen_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } meas_state_e;

  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/pulse_interval_meter_if.sv
// Measurement port: pulse markers in, result handshake and busy out.
interface pulse_interval_meter_if #(
  parameter int CNT_W = 16
);

  logic             start_pulse;
  logic             stop_pulse;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_data;
  logic             meas_timeout;
  logic             busy;

  modport slave (
    input  start_pulse,
    input  stop_pulse,
    input  meas_ready,
    output meas_valid,
    output meas_data,
    output meas_timeout,
    output busy
  );

  modport master (
    output start_pulse,
    output stop_pulse,
    output meas_ready,
    input  meas_valid,
    input  meas_data,
    input  meas_timeout,
    input  busy
  );

endinterface

// File: rtl/pulse_interval_meter_edge_detect.sv
// Rising-edge detector for one pulse marker; PULSE_SYNC_EN adds a 2-flop
// synchronizer in front so the marker may be asynchronous to m_clk.
module pulse_edge_detect (
  input  logic m_clk,
  input  logic m_rst_n,
  input  logic in,
  output logic rise
);

  logic in_s;
  logic in_d;

`ifdef PULSE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], in};
    end
  end

  assign in_s = sync_q[1];
`else
  assign in_s = in;
`endif

  // Delay register clears to 0 so a marker already high after reset is a rise
  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      in_d <= 1'b0;
    end else begin
      in_d <= in_s;
    end
  end

  assign rise = in_s & ~in_d;

endmodule

// File: rtl/pulse_interval_meter.sv
// Counts m_clk cycles from a start rising edge to the next stop rising edge,
// with timeout; PULSE_SYNC_EN synchronizes both markers (adds 2 cycles latency).
module pulse_interval_meter
  import fgen_meas_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                   m_clk,
  input logic                   m_rst_n,
  pulse_interval_meter_if.slave meas
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic             start_rise;
  logic             stop_rise;
  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             timeout_q, timeout_d;
  logic             valid_q;
  logic             busy_q;

  pulse_edge_detect u_start_edge (
    .m_clk   (m_clk),
    .m_rst_n (m_rst_n),
    .in      (meas.start_pulse),
    .rise    (start_rise)
  );

  pulse_edge_detect u_stop_edge (
    .m_clk   (m_clk),
    .m_rst_n (m_rst_n),
    .in      (meas.stop_pulse),
    .rise    (stop_rise)
  );

  // valid and busy are registered from the next state so they track state_q
  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
      valid_q   <= (state_d == HOLD);
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          cnt_d   = CNT_W'(1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A stop edge beats a simultaneous timeout
        if (stop_rise) begin
          data_d    = cnt_q;
          timeout_d = 1'b0;
          state_d   = HOLD;
        end else if (cnt_q == TIMEOUT_VAL) begin
          data_d    = TIMEOUT_VAL;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (valid_q && meas.meas_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign meas.meas_valid   = valid_q;
  assign meas.meas_data    = data_q;
  assign meas.meas_timeout = timeout_q;
  assign meas.busy         = busy_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Scoreboard bench for pulse_interval_meter: random start/stop intervals
// against an interval/timeout reference; honours PULSE_SYNC_EN latency.
module tb_pulse_interval_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
`ifdef PULSE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    int edge_no;
    int data;
    bit to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t cur;
  bit   prev_valid = 1'b0;
  bit   prev_ready = 1'b0;

  pulse_interval_meter_if #(.CNT_W(CNT_W)) mif ();

  pulse_interval_meter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .m_clk   (clk),
    .m_rst_n (rst_n),
    .meas    (mif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One measurement: the interval is the edge distance start->stop, or TIMEOUT
  // with the timeout flag when no stop arrives. hold = cycles ready stays low.
  task automatic applyStimulus(input int len, input bit has_stop, input bit same_stop,
                               input int hold, input bit extra_start);
    int   ws, wp, mid, eff, t_s, k_end;
    bit   junk;
    exp_t e;
    ws  = $urandom_range(1, 3);
    wp  = $urandom_range(1, 3);
    mid = ws + $urandom_range(1, 6);
    eff = has_stop ? len : TIMEOUT;
    t_s = cyc + 1;
    e.edge_no = t_s + eff + SYNC_LAT;
    e.data    = eff;
    e.to      = !has_stop;
    sb.push_back(e);
    k_end = eff + SYNC_LAT + hold + 2;
    for (int k = 0; k <= k_end; k++) begin
      junk = (hold > 0) && (k >= eff + 1) && (k <= eff + hold + 1);
      if (junk) begin
        mif.start_pulse = 1'($urandom_range(0, 1));
        mif.stop_pulse  = 1'($urandom_range(0, 1));
      end else begin
        mif.start_pulse = (k < ws) || (extra_start && k == mid && mid < eff);
        mif.stop_pulse  = (same_stop && k == 0) || (has_stop && k >= len && k < len + wp);
      end
      mif.meas_ready = (hold == 0) || (k >= eff + SYNC_LAT + 1 + hold);
      tick();
    end
    mif.start_pulse = 1'b0;
    mif.stop_pulse  = 1'b0;
    mif.meas_ready  = 1'b1;
    repeat (3) tick();
    checkOutput("idle_busy", mif.busy, 0);
    checkOutput("idle_valid", mif.meas_valid, 0);
  endtask

  // Monitor: pops one expectation per rising meas_valid
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (mif.meas_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checkOutput("valid_without_expectation", mif.meas_valid, 0);
        end else begin
          cur = sb.pop_front();
          checkOutput("valid_edge", cyc, cur.edge_no);
          checkOutput("meas_data", mif.meas_data, cur.data);
          checkOutput("meas_timeout", mif.meas_timeout, cur.to);
        end
      end else if (mif.meas_valid) begin
        checkOutput("hold_data", mif.meas_data, cur.data);
        checkOutput("hold_timeout", mif.meas_timeout, cur.to);
      end
      if (mif.meas_valid) checkOutput("busy_in_hold", mif.busy, 1);
      if (prev_valid && prev_ready) checkOutput("valid_drop_after_accept", mif.meas_valid, 0);
      prev_valid = mif.meas_valid;
      prev_ready = mif.meas_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len, hold;
    bit hs, same, extra;
    rst_n           = 1'b0;
    mif.start_pulse = 1'b1;
    mif.stop_pulse  = 1'b0;
    mif.meas_ready  = 1'b1;
    #1;
    checkOutput("reset_valid", mif.meas_valid, 0);
    checkOutput("reset_data", mif.meas_data, 0);
    checkOutput("reset_timeout", mif.meas_timeout, 0);
    checkOutput("reset_busy", mif.busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // start already high when reset releases; interval 25
    applyStimulus(25, 1'b1, 1'b0, 0, 1'b0);
    // start and stop together, then stop 7 cycles later
    applyStimulus(7, 1'b1, 1'b1, 0, 1'b0);
    // missing stop -> timeout; stop exactly at the timeout count wins
    applyStimulus(0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(TIMEOUT, 1'b1, 1'b0, 0, 1'b1);
    // result held for 20 cycles with ready low and pulse noise, then 9
    applyStimulus(40, 1'b1, 1'b0, 20, 1'b0);
    applyStimulus(9, 1'b1, 1'b0, 0, 1'b0);

    // reset in the middle of a measurement
    mif.start_pulse = 1'b1;
    tick();
    mif.start_pulse = 1'b0;
    repeat (16) tick();
    checkOutput("busy_counting", mif.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", mif.meas_valid, 0);
    checkOutput("midrst_data", mif.meas_data, 0);
    checkOutput("midrst_timeout", mif.meas_timeout, 0);
    checkOutput("midrst_busy", mif.busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    applyStimulus(12, 1'b1, 1'b0, 0, 1'b0);

    // stop pulses alone in IDLE never start anything
    for (int i = 0; i < 20; i++) begin
      mif.stop_pulse = 1'($urandom_range(0, 1));
      tick();
      checkOutput("idle_stop_busy", mif.busy, 0);
    end
    mif.stop_pulse = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 20; i++) begin
      hs    = ($urandom_range(0, 7) != 0);
      len   = $urandom_range(1, TIMEOUT);
      hold  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
      same  = (len >= 2) && ($urandom_range(0, 3) == 0);
      extra = 1'($urandom_range(0, 1));
      applyStimulus(len, hs, same, hold, extra);
    end

    repeat (5) tick();
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
